// File: rtl/esp_pkg.sv
// esp_pkg: shared FSM state codes, ASCII constants and default key for the ESP8266 receive-path parsers
package esp_pkg;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HUNT = 3'd1;
    localparam logic [2:0] ST_SIGN = 3'd2;
    localparam logic [2:0] ST_INT  = 3'd3;
    localparam logic [2:0] ST_DOT  = 3'd4;
    localparam logic [2:0] ST_FRAC = 3'd5;
    localparam logic [2:0] ST_SKIP = 3'd6;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [63:0] DEF_KEY_STR = 64'("\"temp\":");
    localparam int DEF_KEY_LEN = 7;
endpackage

// File: rtl/weather_resp_parser_if.sv
// weather_resp_parser_if: byte stream in, parsed temperature out
//   rx_data/rx_flag : received byte and its one-cycle strobe
//   parse_en        : parser enable (controller cfg_done)
//   temp_x10        : signed temperature x10, temp_valid strobes on update
//   parse_err       : one-cycle pulse on malformed number or timeout
//   busy            : parser is inside a number
//   master drives the stream, slave is the parser
interface weather_resp_parser_if;
    logic [7:0]         rx_data;
    logic               rx_flag;
    logic               parse_en;
    logic signed [11:0] temp_x10;
    logic               temp_valid;
    logic               parse_err;
    logic               busy;
    modport master (output rx_data, rx_flag, parse_en, input temp_x10, temp_valid, parse_err, busy);
    modport slave  (input rx_data, rx_flag, parse_en, output temp_x10, temp_valid, parse_err, busy);
endinterface

// File: rtl/key_matcher.sv
// key_matcher: KEY_LEN-byte shift window that flags when the newest byte completes KEY_STR
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : empty the window
//   i_shift  : shift i_byte into the window
//   o_match  : high in the same cycle as the shift that completes the key
module key_matcher
    import esp_pkg::*;
#(
    parameter logic [63:0] KEY_STR = DEF_KEY_STR,
    parameter int          KEY_LEN = DEF_KEY_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_shift,
    input  logic [7:0] i_byte,
    output logic       o_match
);
    localparam int W = 8 * KEY_LEN;
    logic [W-1:0] r_win;
    logic [W-1:0] w_next;
    assign w_next = (r_win << 8) | W'(i_byte);
    // Combinational so a byte arriving right after the key is not lost.
    assign o_match = i_shift && (w_next == KEY_STR[W-1:0]);
    always_ff @(posedge clk or posedge rst)
        if (rst) r_win <= '0;
        else if (i_clr) r_win <= '0;
        else if (i_shift) r_win <= w_next;
endmodule

// File: rtl/weather_resp_parser.sv
// weather_resp_parser: scans the HTTP response for KEY_STR and converts the following number to tenths of a degree
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   bus (slave)      : rx_data/rx_flag/parse_en in; temp_x10/temp_valid/parse_err/busy out
//   Macro PARSE_TIMEOUT_EN: builds an inter-byte timeout (TIMEOUT_MS) while inside a number.
module weather_resp_parser
    import esp_pkg::*;
#(
    parameter int          CLK_FRE    = 50_000_000,
    parameter int          TIMEOUT_MS = 20,
    parameter logic [63:0] KEY_STR    = DEF_KEY_STR,
    parameter int          KEY_LEN    = DEF_KEY_LEN
) (
    input logic sys_clk,
    input logic sys_rst,
    weather_resp_parser_if.slave bus
);
    logic [2:0]         r_state;
    logic               r_neg;
    logic [6:0]         r_acc;
    logic [1:0]         r_ndig;
    logic [3:0]         r_frac;
    logic signed [11:0] r_temp;
    logic               r_valid;
    logic               r_err;
    logic [2:0]         w_state_n;
    logic               w_rx, w_digit, w_minus, w_dot, w_space;
    logic               w_match, w_clr, w_commit, w_err, w_tout, w_busy;
    logic [3:0]         w_d;
    logic [11:0]        w_mag;
    assign w_rx    = bus.rx_flag;
    assign w_digit = (bus.rx_data >= CH_0) && (bus.rx_data <= CH_9);
    assign w_minus = bus.rx_data == CH_MINUS;
    assign w_dot   = bus.rx_data == CH_DOT;
    assign w_space = bus.rx_data == CH_SPACE;
    assign w_d     = bus.rx_data[3:0];
    assign w_busy  = (r_state != ST_IDLE) && (r_state != ST_HUNT);
    assign w_mag   = {5'd0, r_acc} * 12'd10 + {8'd0, r_frac};
    assign w_clr   = !bus.parse_en || (r_state == ST_IDLE) || w_commit || w_err;
    key_matcher #(.KEY_STR(KEY_STR), .KEY_LEN(KEY_LEN)) u_key (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_clr   (w_clr),
        .i_shift (w_rx && bus.parse_en && (r_state == ST_HUNT)),
        .i_byte  (bus.rx_data),
        .o_match (w_match)
    );
`ifdef PARSE_TIMEOUT_EN
    localparam int LIMIT = CLK_FRE / 1000 * TIMEOUT_MS;
    logic [31:0] r_cnt;
    assign w_tout = w_busy && !w_rx && (r_cnt == 32'(LIMIT - 1));
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) r_cnt <= '0;
        else r_cnt <= (!w_busy || w_rx || w_tout) ? '0 : r_cnt + 32'd1;
`else
    assign w_tout = 1'b0;
`endif
    always_comb begin
        w_state_n = r_state;
        w_commit  = 1'b0;
        w_err     = w_tout;
        if (w_rx) begin
            case (r_state)
                ST_HUNT: w_state_n = w_match ? ST_SIGN : ST_HUNT;
                ST_SIGN: begin
                    w_state_n = (w_digit || w_minus) ? ST_INT : ST_SIGN;
                    w_err     = !(w_digit || w_minus || w_space);
                end
                ST_INT: begin
                    // No digit yet means a bare '-': anything but a digit is malformed.
                    w_state_n = w_dot ? ST_DOT : ST_INT;
                    w_err     = (r_ndig == 2'd0) ? !w_digit : (w_digit && r_ndig == 2'd2);
                    w_commit  = (r_ndig != 2'd0) && !w_digit && !w_dot;
                end
                ST_DOT: begin
                    w_state_n = ST_FRAC;
                    w_err     = !w_digit;
                end
                ST_FRAC: begin
                    w_state_n = ST_SKIP;
                    w_commit  = !w_digit;
                end
                ST_SKIP: w_commit = !w_digit;
                default: w_state_n = r_state;
            endcase
        end
        if (r_state == ST_IDLE) w_state_n = ST_HUNT;
        if (w_commit || w_err) w_state_n = ST_HUNT;
        if (!bus.parse_en) begin
            w_state_n = ST_IDLE;
            w_commit  = 1'b0;
            w_err     = 1'b0;
        end
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_ndig  <= '0;
            r_frac  <= '0;
            r_temp  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_valid <= w_commit;
            r_err   <= w_err;
            if (w_commit) r_temp <= r_neg ? -w_mag : w_mag;
            if (w_match) begin
                r_neg  <= 1'b0;
                r_acc  <= '0;
                r_ndig <= '0;
                r_frac <= '0;
            end else if (w_rx && bus.parse_en) begin
                if (r_state == ST_SIGN && w_minus) r_neg <= 1'b1;
                // The first digit lands on a cleared accumulator, so SIGN and INT share the update.
                if ((r_state == ST_SIGN || r_state == ST_INT) && w_digit && r_ndig != 2'd2) begin
                    r_acc  <= r_acc * 7'd10 + {3'd0, w_d};
                    r_ndig <= r_ndig + 2'd1;
                end
                if (r_state == ST_DOT && w_digit) r_frac <= w_d;
            end
        end
    end
    assign bus.temp_x10   = r_temp;
    assign bus.temp_valid = r_valid;
    assign bus.parse_err  = r_err;
    assign bus.busy       = w_busy;
endmodule

// File: tb/tb_weather_resp_parser.sv
// tb_weather_resp_parser: directed-vector bench for weather_resp_parser
module tb_weather_resp_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_consec = 0;
    logic prev_pulse = 1'b0;
    weather_resp_parser_if bus ();
`ifdef PARSE_TIMEOUT_EN
    weather_resp_parser #(.TIMEOUT_MS(1)) dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));
`else
    weather_resp_parser dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));
`endif
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.temp_valid) n_valid++;
        if (bus.parse_err) n_err++;
        if (prev_pulse && (bus.temp_valid || bus.parse_err)) n_consec++;
        prev_pulse = bus.temp_valid || bus.parse_err;
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.rx_data = s[i];
            bus.rx_flag = 1'b1;
            tick(1);
        end
        bus.rx_flag = 1'b0;
    endtask
    task automatic test_reset;
        checks++;
        if (bus.temp_x10 !== 12'd0) begin errors++; $display("FAIL reset_temp: got %0d expected 0", bus.temp_x10); end
        checks++;
        if ({bus.temp_valid, bus.parse_err, bus.busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.temp_valid, bus.parse_err, bus.busy}); end
    endtask
    task automatic test_basic;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_str("{\"temp\":23.5}");
        checks++;
        if (bus.temp_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got valid=%b expected 1", bus.temp_valid); end
        checks++;
        if (bus.temp_x10 !== 12'd235) begin errors++; $display("FAIL basic_value: got %0d expected 235", bus.temp_x10); end
        tick(1);
        checks++;
        if (bus.temp_valid !== 1'b0) begin errors++; $display("FAIL basic_single: got valid=%b expected 0", bus.temp_valid); end
        checks++;
        if (n_valid - v0 != 1 || n_err != e0) begin errors++; $display("FAIL basic_pulses: got valid=%0d err=%0d expected 1 0", n_valid - v0, n_err - e0); end
    endtask
    task automatic test_negative;
        send_str("\"temp\": -7,");
        checks++;
        if (bus.temp_valid !== 1'b1 || bus.temp_x10 !== 12'hFBA) begin errors++; $display("FAIL negative: got valid=%b temp=%h expected 1 fba", bus.temp_valid, bus.temp_x10); end
        tick(1);
    endtask
    task automatic test_overflow;
        send_str("\"temp\":123");
        checks++;
        if (bus.parse_err !== 1'b1 || bus.temp_valid !== 1'b0) begin errors++; $display("FAIL overflow_err: got err=%b valid=%b expected 1 0", bus.parse_err, bus.temp_valid); end
        checks++;
        if (bus.temp_x10 !== 12'hFBA) begin errors++; $display("FAIL overflow_hold: got %h expected fba", bus.temp_x10); end
        send_str("}\"temp\":5}");
        checks++;
        if (bus.temp_valid !== 1'b1 || bus.temp_x10 !== 12'd50) begin errors++; $display("FAIL after_overflow: got valid=%b temp=%0d expected 1 50", bus.temp_valid, bus.temp_x10); end
        tick(1);
    endtask
    task automatic test_fraction;
        send_str("\"temp\":18.76}");
        checks++;
        if (bus.temp_valid !== 1'b1 || bus.temp_x10 !== 12'd187) begin errors++; $display("FAIL truncate: got valid=%b temp=%0d expected 1 187", bus.temp_valid, bus.temp_x10); end
        tick(1);
        send_str("\"temp\":4.}");
        checks++;
        if (bus.parse_err !== 1'b1 || bus.temp_x10 !== 12'd187) begin errors++; $display("FAIL dot_nodigit: got err=%b temp=%0d expected 1 187", bus.parse_err, bus.temp_x10); end
        tick(1);
    endtask
    task automatic test_en_drop;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_str("\"temp\":2");
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_in_number: got %b expected 1", bus.busy); end
        bus.parse_en = 1'b0;
        tick(3);
        checks++;
        if (bus.busy !== 1'b0 || n_valid != v0 || n_err != e0) begin errors++; $display("FAIL en_drop: got busy=%b pulses=%0d expected 0 0", bus.busy, n_valid - v0 + n_err - e0); end
        bus.parse_en = 1'b1;
        tick(1);
        send_str("\"temp\":9}");
        checks++;
        if (bus.temp_valid !== 1'b1 || bus.temp_x10 !== 12'd90) begin errors++; $display("FAIL en_resume: got valid=%b temp=%0d expected 1 90", bus.temp_valid, bus.temp_x10); end
        tick(1);
    endtask
    task automatic test_en_priority;
        send_str("\"temp\":3");
        bus.rx_data = "}";
        bus.rx_flag = 1'b1;
        bus.parse_en = 1'b0;
        tick(1);
        bus.rx_flag = 1'b0;
        checks++;
        if (bus.temp_valid !== 1'b0 || bus.parse_err !== 1'b0 || bus.temp_x10 !== 12'd90) begin errors++; $display("FAIL en_priority: got valid=%b err=%b temp=%0d expected 0 0 90", bus.temp_valid, bus.parse_err, bus.temp_x10); end
        bus.parse_en = 1'b1;
        tick(1);
    endtask
    task automatic test_malformed;
        send_str("\"temp\":-0.0}");
        checks++;
        if (bus.temp_valid !== 1'b1 || bus.temp_x10 !== 12'd0) begin errors++; $display("FAIL neg_zero: got valid=%b temp=%0d expected 1 0", bus.temp_valid, bus.temp_x10); end
        send_str("\"temp\":-.");
        checks++;
        if (bus.parse_err !== 1'b1) begin errors++; $display("FAIL minus_nondigit: got err=%b expected 1", bus.parse_err); end
        send_str("\"temp\":x");
        checks++;
        if (bus.parse_err !== 1'b1 || bus.temp_x10 !== 12'd0) begin errors++; $display("FAIL bad_sign: got err=%b temp=%0d expected 1 0", bus.parse_err, bus.temp_x10); end
        tick(1);
    endtask
    task automatic test_stall;
        int e0;
        logic got;
        e0 = n_err;
        got = 1'b0;
        send_str("\"temp\":2");
`ifdef PARSE_TIMEOUT_EN
        for (int i = 0; i < 50010 && !got; i++) begin
            @(negedge clk);
            got = bus.parse_err;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL timeout: got no parse_err expected pulse within 50000 cycles"); end
        tick(1);
        checks++;
        if (bus.busy !== 1'b0 || bus.temp_x10 !== 12'd0) begin errors++; $display("FAIL timeout_state: got busy=%b temp=%0d expected 0 0", bus.busy, bus.temp_x10); end
`else
        tick(2000);
        checks++;
        if (n_err != e0 || bus.busy !== 1'b1) begin errors++; $display("FAIL stall: got err=%0d busy=%b expected 0 1", n_err - e0, bus.busy); end
        send_str("}");
        checks++;
        if (bus.temp_valid !== 1'b1 || bus.temp_x10 !== 12'd20) begin errors++; $display("FAIL stall_resume: got valid=%b temp=%0d expected 1 20", bus.temp_valid, bus.temp_x10); end
        tick(1);
`endif
    endtask
    task automatic test_back_to_back;
        int v0;
        v0 = n_valid;
        send_str("\"temp\":1}\"temp\":7}");
        tick(1);
        checks++;
        if (n_valid - v0 != 2 || bus.temp_x10 !== 12'd70) begin errors++; $display("FAIL back_to_back: got pulses=%0d temp=%0d expected 2 70", n_valid - v0, bus.temp_x10); end
        checks++;
        if (n_consec != 0) begin errors++; $display("FAIL pulse_spacing: got %0d adjacent pulses expected 0", n_consec); end
    endtask
    task automatic test_reset_mid;
        send_str("\"temp\":4");
        rst = 1'b1;
        #1;
        checks++;
        if (bus.temp_x10 !== 12'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid: got temp=%0d busy=%b expected 0 0", bus.temp_x10, bus.busy); end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask
    initial begin
        bus.rx_data = 8'd0;
        bus.rx_flag = 1'b0;
        bus.parse_en = 1'b0;
        tick(3);
        test_reset;
        rst = 1'b0;
        bus.parse_en = 1'b1;
        tick(2);
        test_basic;
        test_negative;
        test_overflow;
        test_fraction;
        test_en_drop;
        test_en_priority;
        test_malformed;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
